// File: rtl/pid_ctrl.sv
// Purpose : PID motor-drive controller turning the signed current error into a 12-bit drive magnitude.
// Latency : 2 cycles from error/not_pedaling to drv_mag; integrator and D history move on a decimated tick.
// Backpressure: none; the PWM stage samples drv_mag every cycle and the block never stalls.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   error        13-bit two's complement current error (target - average)
//   not_pedaling high clears the integrator and forces drv_mag to 0
//   drv_mag      12-bit unsigned drive magnitude, registered
module pid_ctrl #(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [12:0] error,
    input  logic        not_pedaling,
    output logic [11:0] drv_mag
);

    // ------------------------------------------------------------------
    // Decimator: free-running counter, tick when the selected low bits
    // are all ones (period 2^15 or 2^20 clocks).
    // ------------------------------------------------------------------
    logic [19:0] decim_cnt;
    logic        tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decim_cnt <= 20'd0;
        end else begin
            decim_cnt <= decim_cnt + 20'd1;
        end
    end

    assign tick = FAST_SIM ? (&decim_cnt[14:0]) : (&decim_cnt);

    // ------------------------------------------------------------------
    // P term: the error itself, widened to the 15-bit summing width.
    // ------------------------------------------------------------------
    logic [14:0] p_term;

    assign p_term = {{2{error[12]}}, error};

    // ------------------------------------------------------------------
    // Integrator: clamped to 0..0x1FFFF so it can neither go negative
    // nor wrap. not_pedaling wins over a coincident tick.
    // ------------------------------------------------------------------
    logic [17:0] integ;
    logic [17:0] integ_sum;
    logic [17:0] integ_nxt;
    logic [14:0] i_term;

    assign integ_sum = integ + {{5{error[12]}}, error};

    always_comb begin
        integ_nxt = integ;
        if (not_pedaling) begin
            integ_nxt = 18'd0;
        end else if (tick) begin
            if (!integ[17] && !error[12] && integ_sum[17]) begin
                // both operands non-negative but the sign flipped: overflow
                integ_nxt = 18'h1FFFF;
            end else if (integ_sum[17]) begin
                integ_nxt = 18'd0;
            end else begin
                integ_nxt = integ_sum;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ <= 18'd0;
        end else begin
            integ <= integ_nxt;
        end
    end

    // Integrator is scaled down by 16; bit 17 is always 0 here.
    assign i_term = {2'b00, integ[16:4]};

    // ------------------------------------------------------------------
    // D term: error minus the sample from three ticks ago. The history
    // keeps shifting while not pedaling so the derivative is meaningful
    // the moment the rider starts again.
    // ------------------------------------------------------------------
    logic [12:0] prev0;
    logic [12:0] prev1;
    logic [12:0] prev2;
    logic [13:0] diff;
    logic [9:0]  diff_sat;
    logic [14:0] d_term;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev0 <= 13'd0;
            prev1 <= 13'd0;
            prev2 <= 13'd0;
        end else if (tick) begin
            prev0 <= error;
            prev1 <= prev0;
            prev2 <= prev1;
        end
    end

    assign diff = {error[12], error} - {prev2[12], prev2};

    // Saturate to the 10-bit signed range: the upper bits [12:9] must all
    // equal the sign bit for the value to fit.
    always_comb begin
        diff_sat = diff[9:0];
        if (!diff[13] && (diff[12:9] != 4'h0)) begin
            diff_sat = 10'h1FF;
        end else if (diff[13] && (diff[12:9] != 4'hF)) begin
            diff_sat = 10'h200;
        end
    end

    assign d_term = {{4{diff_sat[9]}}, diff_sat, 1'b0};

    // ------------------------------------------------------------------
    // Pipeline stage 1: register the three terms and the pedal flag.
    // ------------------------------------------------------------------
    logic [14:0] p_r;
    logic [14:0] i_r;
    logic [14:0] d_r;
    logic        np_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r  <= 15'd0;
            i_r  <= 15'd0;
            d_r  <= 15'd0;
            np_r <= 1'b0;
        end else begin
            p_r  <= p_term;
            i_r  <= i_term;
            d_r  <= d_term;
            np_r <= not_pedaling;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline stage 2: sum and clamp to 0..4095. The term ranges keep
    // the 15-bit sum within -5120..13308, so it cannot wrap.
    // ------------------------------------------------------------------
    logic [14:0] sum15;
    logic [11:0] drv_nxt;

    assign sum15 = p_r + i_r + d_r;

    always_comb begin
        drv_nxt = sum15[11:0];
        if (np_r) begin
            drv_nxt = 12'd0;
        end else if (sum15[14]) begin
            drv_nxt = 12'd0;
        end else if (sum15[13:12] != 2'b00) begin
            drv_nxt = 12'hFFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_mag <= 12'd0;
        end else begin
            drv_mag <= drv_nxt;
        end
    end

endmodule

// File: tb/tb_pid_ctrl.sv
// Purpose : directed-vector bench for pid_ctrl with hand-computed drive values.
// Latency : checks the 2-edge error-to-drive latency and the 32768-clock tick period.
// Backpressure: none; stimulus is driven 1 time unit after each rising edge.
module tb_pid_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [12:0] error;
    logic        not_pedaling;
    logic [11:0] drv_mag;

    int vectors     = 0;
    int miscompares = 0;

    pid_ctrl #(.FAST_SIM(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .error        (error),
        .not_pedaling (not_pedaling),
        .drv_mag      (drv_mag)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 unit past the last one.
    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Jump the decimator so the current cycle is a tick cycle, let the
    // tick edge happen, then put the counter safely past the tick.
    task automatic do_tick();
        force dut.decim_cnt = 20'h07FFF;
        @(posedge clk);
        #1;
        force dut.decim_cnt = 20'h08000;
        #1;
        release dut.decim_cnt;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        error        = 13'd1000;
        not_pedaling = 1'b0;
        edges(3);
        vectors++;
        if (drv_mag !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_hold_drv: got %0d expected 0", drv_mag);
        end
        vectors++;
        if (dut.decim_cnt !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_hold_cnt: got %0d expected 0", dut.decim_cnt);
        end
        rst_n = 1'b1;
        edges(1);
        vectors++;
        if (drv_mag !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_release_1: got %0d expected 0", drv_mag);
        end
        edges(1);
        // P=1000, D=2*sat(1000)=1022, I=0
        vectors++;
        if (drv_mag !== 12'd2022) begin
            miscompares++;
            $display("FAIL reset_release_2: got %0d expected 2022", drv_mag);
        end
    endtask

    task automatic test_step();
        rst_n = 1'b0;
        error = 13'd100;
        edges(1);
        rst_n = 1'b1;
        edges(2);
        vectors++;
        if (drv_mag !== 12'd300) begin
            miscompares++;
            $display("FAIL step_first: got %0d expected 300", drv_mag);
        end
        edges(32765);
        vectors++;
        if (dut.decim_cnt !== 20'h07FFF || dut.integ !== 18'd0) begin
            miscompares++;
            $display("FAIL step_pre_tick: cnt=%0h integ=%0d expected cnt=7fff integ=0",
                     dut.decim_cnt, dut.integ);
        end
        edges(1);
        vectors++;
        if (dut.integ !== 18'd100 || dut.prev0 !== 13'd100) begin
            miscompares++;
            $display("FAIL step_tick1: integ=%0d prev0=%0d expected 100/100", dut.integ, dut.prev0);
        end
        edges(1);
        vectors++;
        if (drv_mag !== 12'd300) begin
            miscompares++;
            $display("FAIL step_tick1_lat: got %0d expected 300", drv_mag);
        end
        edges(1);
        vectors++;
        if (drv_mag !== 12'd306) begin
            miscompares++;
            $display("FAIL step_tick1_drv: got %0d expected 306", drv_mag);
        end
        do_tick();
        edges(2);
        // integ=200 -> I=12, prev2 still 0 -> D=200
        vectors++;
        if (drv_mag !== 12'd312) begin
            miscompares++;
            $display("FAIL step_tick2_drv: got %0d expected 312", drv_mag);
        end
        do_tick();
        vectors++;
        if (dut.integ !== 18'd300) begin
            miscompares++;
            $display("FAIL step_tick3_integ: got %0d expected 300", dut.integ);
        end
        edges(2);
        vectors++;
        if (drv_mag !== 12'd118) begin
            miscompares++;
            $display("FAIL step_tick3_drv: got %0d expected 118", drv_mag);
        end
    endtask

    task automatic test_negative();
        error = 13'h1830;   // -2000
        edges(2);
        vectors++;
        if (drv_mag !== 12'd0) begin
            miscompares++;
            $display("FAIL neg_drv: got %0d expected 0", drv_mag);
        end
        do_tick();
        vectors++;
        if (dut.integ !== 18'd0) begin
            miscompares++;
            $display("FAIL neg_integ_clamp: got %0d expected 0", dut.integ);
        end
        do_tick();
        vectors++;
        if (dut.integ !== 18'd0) begin
            miscompares++;
            $display("FAIL neg_integ_hold: got %0d expected 0", dut.integ);
        end
        edges(2);
        vectors++;
        if (drv_mag !== 12'd0) begin
            miscompares++;
            $display("FAIL neg_drv_after: got %0d expected 0", drv_mag);
        end
    endtask

    task automatic test_max();
        error = 13'd4095;
        edges(2);
        vectors++;
        if (drv_mag !== 12'hFFF) begin
            miscompares++;
            $display("FAIL max_drv_now: got %0h expected fff", drv_mag);
        end
        for (int k = 0; k < 32; k++) begin
            do_tick();
        end
        vectors++;
        if (dut.integ !== 18'h1FFE0) begin
            miscompares++;
            $display("FAIL max_integ_32: got %0h expected 1ffe0", dut.integ);
        end
        do_tick();
        vectors++;
        if (dut.integ !== 18'h1FFFF) begin
            miscompares++;
            $display("FAIL max_integ_sat: got %0h expected 1ffff", dut.integ);
        end
        do_tick();
        vectors++;
        if (dut.integ !== 18'h1FFFF) begin
            miscompares++;
            $display("FAIL max_integ_nowrap: got %0h expected 1ffff", dut.integ);
        end
        edges(2);
        vectors++;
        if (drv_mag !== 12'hFFF) begin
            miscompares++;
            $display("FAIL max_drv_sat: got %0h expected fff", drv_mag);
        end
    endtask

    task automatic test_not_pedaling();
        rst_n = 1'b0;
        error = 13'd200;
        edges(1);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            do_tick();
        end
        vectors++;
        if (dut.integ !== 18'd1000) begin
            miscompares++;
            $display("FAIL np_build: got %0d expected 1000", dut.integ);
        end
        edges(2);
        vectors++;
        if (drv_mag !== 12'd262) begin
            miscompares++;
            $display("FAIL np_before: got %0d expected 262", drv_mag);
        end
        not_pedaling = 1'b1;
        edges(1);
        vectors++;
        if (dut.integ !== 18'd0 || drv_mag !== 12'd262) begin
            miscompares++;
            $display("FAIL np_edge1: integ=%0d drv=%0d expected 0/262", dut.integ, drv_mag);
        end
        edges(1);
        vectors++;
        if (drv_mag !== 12'd0) begin
            miscompares++;
            $display("FAIL np_edge2: got %0d expected 0", drv_mag);
        end
        // Tick while not pedaling: history shifts, integrator stays clear.
        error = 13'd500;
        do_tick();
        vectors++;
        if (dut.integ !== 18'd0 || dut.prev0 !== 13'd500) begin
            miscompares++;
            $display("FAIL np_tick: integ=%0d prev0=%0d expected 0/500", dut.integ, dut.prev0);
        end
        error = 13'd200;
        edges(7);
        vectors++;
        if (drv_mag !== 12'd0) begin
            miscompares++;
            $display("FAIL np_hold: got %0d expected 0", drv_mag);
        end
        not_pedaling = 1'b0;
        edges(1);
        vectors++;
        if (drv_mag !== 12'd0) begin
            miscompares++;
            $display("FAIL np_release_1: got %0d expected 0", drv_mag);
        end
        edges(1);
        vectors++;
        if (drv_mag !== 12'd200) begin
            miscompares++;
            $display("FAIL np_release_2: got %0d expected 200", drv_mag);
        end
        do_tick();
        edges(2);
        vectors++;
        if (drv_mag !== 12'd212) begin
            miscompares++;
            $display("FAIL np_restart: got %0d expected 212", drv_mag);
        end
    endtask

    task automatic test_async_reset();
        error = 13'd4095;
        edges(2);
        vectors++;
        if (drv_mag !== 12'hFFF) begin
            miscompares++;
            $display("FAIL arst_pre: got %0h expected fff", drv_mag);
        end
        #3;
        rst_n = 1'b0;
        error = 13'd100;
        #1;
        vectors++;
        if (drv_mag !== 12'd0 || dut.integ !== 18'd0 || dut.decim_cnt !== 20'd0) begin
            miscompares++;
            $display("FAIL arst_now: drv=%0d integ=%0d cnt=%0d expected 0/0/0",
                     drv_mag, dut.integ, dut.decim_cnt);
        end
        edges(1);
        rst_n = 1'b1;
        edges(2);
        vectors++;
        if (drv_mag !== 12'd300) begin
            miscompares++;
            $display("FAIL arst_resume: got %0d expected 300", drv_mag);
        end
        edges(32765);
        vectors++;
        if (dut.integ !== 18'd0) begin
            miscompares++;
            $display("FAIL arst_no_early_tick: got %0d expected 0", dut.integ);
        end
        edges(1);
        vectors++;
        if (dut.integ !== 18'd100) begin
            miscompares++;
            $display("FAIL arst_tick: got %0d expected 100", dut.integ);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        error        = 13'd0;
        not_pedaling = 1'b0;
        #1;
        test_reset();
        test_step();
        test_negative();
        test_max();
        test_not_pedaling();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pid_ctrl.md
# pid_ctrl

Closed-loop motor-drive controller that sits directly downstream of `sensorCondition`. It consumes the registered signed current `error` and the `not_pedaling` flag. It produces the 12-bit unsigned drive magnitude `drv_mag` for the brushless commutation/PWM stage. P, I and D terms are computed in a 2-stage pipeline; the integrator and derivative history update only on a decimated sample tick.

## Interface
- FAST_SIM, default 1, selects the decimation period: 1 gives 2^15 clocks per tick, 0 gives 2^20 clocks per tick.
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- error  input  13  signed current error (target − average), two's complement, range −4096..4095.
- not_pedaling  input  1  high while the rider is not pedaling; clears the integrator and zeroes the drive.
- drv_mag  output  12  unsigned drive magnitude to the PWM stage, 0..4095.

## Operation
- **Decimator**
  - 20-bit free-running counter `decim_cnt`, increments every cycle and wraps.
  - `tick` = &decim_cnt[14:0] when FAST_SIM=1; &decim_cnt[19:0] when FAST_SIM=0.
- **P term**
  - P = error sign-extended to 15 bits.
- **Integrator**
  - 18-bit signed `integ`.
  - If not_pedaling=1 (any cycle, tick or not): `integ` <= 0. This has priority over a tick.
  - Else on tick: sum = integ + sext(error), computed in 18 bits.
    - If sum is negative: `integ` <= 0.
    - Else if positive overflow (integ positive, error positive, sum[17]=1): `integ` <= 18'h1FFFF.
    - Else: `integ` <= sum.
  - `integ` never goes negative and never wraps.
  - I = {2'b00, integ[16:4]}, 15-bit non-negative, max 8191.
- **D term**
  - 3-deep error history `prev0`, `prev1`, `prev2` (13-bit signed), all 0 after reset.
  - On tick: prev0 <= error, prev1 <= prev0, prev2 <= prev1.
  - The history updates regardless of not_pedaling.
  - diff = sext(error) − sext(prev2), 14-bit signed.
  - diff is saturated to 10-bit signed range −512..511.
  - D = 2 × saturated diff, sign-extended to 15 bits; range −1024..1022.
- **Pipeline stage 1** (registers, reset 0): P_r, I_r, D_r, np_r (np_r = not_pedaling).
- **Pipeline stage 2**
  - sum15 = P_r + I_r + D_r, 15-bit signed; range −5120..13308, so no overflow.
  - If np_r=1: drv_mag <= 0.
  - Else if sum15 < 0: drv_mag <= 0.
  - Else if sum15 > 4095: drv_mag <= 12'hFFF.
  - Else: drv_mag <= sum15[11:0].

## Timing
- Reset values: drv_mag=0, decim_cnt=0, integ=0, prev0..2=0, all stage-1 registers 0.
- Async assertion clears everything immediately, including mid-accumulation and mid-tick.
- **Latency from error:** a change on `error` at edge N is reflected in drv_mag after edge N+2, through the P and D paths.
- **Tick timing:**
  - First tick is the cycle where decim_cnt = 0x7FFF (FAST_SIM=1), i.e. after 32767 clocks; ticks then repeat every 32768 clocks.
  - `integ` and the history update on the tick edge; the effect reaches drv_mag 2 edges later.
- **not_pedaling:**
  - Asserted at edge N: `integ`=0 after edge N+1; drv_mag=0 after edge N+2.
  - On deassertion the integrator restarts from 0; drv_mag resumes 2 edges after deassertion.
- **Simultaneous tick and not_pedaling:** the integrator clears and the history still shifts.
- drv_mag changes only on clock edges; there is no combinational path from input to output.

## Test plan
- **Reset:** hold rst_n=0 with error=1000 → drv_mag=0 throughout; release → first nonzero drv_mag appears only after 2 edges.
- **Step error=+100, pedaling, from reset (FAST_SIM=1):**
  - After 2 edges: drv_mag=300 (P=100, D=200, I=0).
  - After the 3rd tick plus 2 edges: history is full, D=0, integ=300, I=18 → drv_mag=118.
- **error=−2000 sustained:** P=−2000, diff saturates to −512 so D=−1024 → drv_mag=0; integ stays 0 across ticks (never negative).
- **error=+4095 sustained:**
  - Immediately: sum=4095+1022 → drv_mag=0xFFF.
  - After ≥33 ticks: integ=0x1FFFF (no wrap to negative) and drv_mag stays 0xFFF.
- **not_pedaling pulse:** build integ>0 with error=+200 over 5 ticks, then assert not_pedaling for 10 cycles.
  - integ=0 next edge; drv_mag=0 within 2 edges.
  - After release with error=+200: drv_mag=200+D, with I=0 until the next tick.
- **Async reset mid-run:** pulse rst_n low between clock edges while drv_mag=0xFFF → drv_mag, integ and decim_cnt read 0 immediately; the next tick occurs 32767 clocks after release.
